// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: MIPS fetch-stage program counter and next-PC sequencer.
// Holds the fetch PC and advances it by 4 each accepted fetch. Jump and branch
// redirects are taken through a two-state FSM (SEQ / PENDING) that models the
// MIPS branch delay slot.
//
// Handshake: a producer raises jump_taken or branch_taken and holds it, with
// its target, until it sees redirect_ack. redirect_ack is combinational and is
// high only in a cycle where the fetch advances (imem_ready & ~stall &
// fetch_valid) while the FSM is in SEQ. The request is consumed on that clock
// edge. A branch that loses to a simultaneous jump is never acked, and its
// producer must squash it.
//
// Optional feature macro: PC_ALIGN_CHECK_EN.
//   defined   : a misaligned target (bits [1:0] != 0) is acked but not followed,
//               and align_fault pulses together with the ack.
//   undefined : align_fault is tied 0, and target bits [1:0] are cleared before use.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DELAY_SLOT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [3:0]  pc_upper,
  output logic        fetch_valid,
  output logic        delay_slot,
  output logic        redirect_ack,
  output logic        align_fault
);

  typedef enum logic {SEQ = 1'b0, PENDING = 1'b1} state_t;

  state_t      state;
  logic [31:0] saved_target;
  logic        advance;
  logic        req;
  logic [31:0] sel_target;
  logic [31:0] use_target;
  logic        follow;

  // Sequential address and the upper bits used to build jump targets.
  assign pc_plus4 = pc + 32'd4;
  assign pc_upper = pc_plus4[31:28];

  // Fetch moves forward only on a valid, accepted, unstalled cycle.
  assign advance = imem_ready & ~stall & fetch_valid;

  // A jump wins over a branch in the same cycle.
  assign req        = jump_taken | branch_taken;
  assign sel_target = jump_taken ? jump_target : branch_target;

  assign redirect_ack = advance & req & (state == SEQ);

`ifdef PC_ALIGN_CHECK_EN
  // A misaligned target is acked so that its producer releases it, but it is not followed.
  assign use_target  = sel_target;
  assign align_fault = redirect_ack & (sel_target[1:0] != 2'b00);
  assign follow      = redirect_ack & (sel_target[1:0] == 2'b00);
`else
  // Low address bits are cleared, so every acked redirect is followed.
  assign use_target  = sel_target & 32'hFFFF_FFFC;
  assign align_fault = 1'b0;
  assign follow      = redirect_ack;
`endif

  // PC register, redirect FSM, saved delay-slot target and fetch_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      state        <= SEQ;
      saved_target <= 32'h0000_0000;
      fetch_valid  <= 1'b0;
      delay_slot   <= 1'b0;
    end else begin
      fetch_valid <= 1'b1;
      if (advance) begin
        case (state)
          SEQ: begin
            if (follow) begin
              if (DELAY_SLOT != 0) begin
                pc           <= pc_plus4;
                saved_target <= use_target;
                delay_slot   <= 1'b1;
                state        <= PENDING;
              end else begin
                pc <= use_target;
              end
            end else begin
              pc <= pc_plus4;
            end
          end
          PENDING: begin
            pc         <= saved_target;
            delay_slot <= 1'b0;
            state      <= SEQ;
          end
          default: begin
            state <= SEQ;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed testbench for pc_redirect_unit (RESET_PC=0040_0000, DELAY_SLOT=1).
// Each step drives inputs, checks the combinational ack and align_fault, then
// pushes the expected post-edge pc, delay_slot and fetch_valid values into
// queues. It pops and compares those values one time unit after the edge.
module tb_pc_redirect_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic        stall;
  logic        jump_taken;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [3:0]  pc_upper;
  logic        fetch_valid;
  logic        delay_slot;
  logic        redirect_ack;
  logic        align_fault;

  logic [31:0] exp_q[$];
  logic        exp_ds_q[$];
  logic        exp_fv_q[$];

  int n_cmp = 0;
  int n_mis = 0;

  // clock / reset
  always #5 clk = ~clk;

  pc_redirect_unit #(.RESET_PC(RPC), .DELAY_SLOT(1)) dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .stall(stall),
    .jump_taken(jump_taken), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .pc_plus4(pc_plus4), .pc_upper(pc_upper),
    .fetch_valid(fetch_valid), .delay_slot(delay_slot),
    .redirect_ack(redirect_ack), .align_fault(align_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock step: drive the inputs, check the combinational outputs, queue the
  // expected values, cross the edge, then pop the queue and compare.
  task automatic step(input string tag, input logic rst, input logic ir, input logic st,
                      input logic jt, input logic [31:0] jtg,
                      input logic bt, input logic [31:0] btg,
                      input logic e_ack, input logic e_af,
                      input logic [31:0] e_pc, input logic e_ds, input logic e_fv);
    logic [31:0] q_pc;
    logic        q_ds;
    logic        q_fv;
    reset = rst; imem_ready = ir; stall = st;
    jump_taken = jt; jump_target = jtg; branch_taken = bt; branch_target = btg;
    #1;
    chk({tag, ".ack"}, {31'b0, redirect_ack}, {31'b0, e_ack});
    chk({tag, ".align_fault"}, {31'b0, align_fault}, {31'b0, e_af});
    exp_q.push_back(e_pc);
    exp_ds_q.push_back(e_ds);
    exp_fv_q.push_back(e_fv);
    @(posedge clk);
    #1;
    q_pc = exp_q.pop_front();
    q_ds = exp_ds_q.pop_front();
    q_fv = exp_fv_q.pop_front();
    chk({tag, ".pc"}, pc, q_pc);
    chk({tag, ".delay_slot"}, {31'b0, delay_slot}, {31'b0, q_ds});
    chk({tag, ".fetch_valid"}, {31'b0, fetch_valid}, {31'b0, q_fv});
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b1; stall = 1'b0;
    jump_taken = 1'b0; jump_target = '0; branch_taken = 1'b0; branch_target = '0;
    @(posedge clk); @(posedge clk); #1;

    // reset state
    chk("rst.pc", pc, RPC);
    chk("rst.fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst.delay_slot", {31'b0, delay_slot}, 32'd0);
    chk("rst.ack", {31'b0, redirect_ack}, 32'd0);
    chk("rst.pc_plus4", pc_plus4, RPC + 32'd4);

    // sequential fetch; the first edge after reset only raises fetch_valid
    step("seq0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 1);
    step("seq1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0004, 0, 1);
    step("seq2", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0008, 0, 1);

    // jump with delay slot
    step("jmp_ack", 0, 1, 0, 1, 32'h0040_0100, 0, 0, 1, 0, 32'h0040_000C, 1, 1);
    step("jmp_tgt", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0100, 0, 1);
    chk("jmp_tgt.pc_plus4", pc_plus4, 32'h0040_0104);
    chk("jmp_tgt.pc_upper", {28'b0, pc_upper}, 32'h0);

    // jump beats branch; a branch raised in PENDING waits for SEQ
    step("both_ack", 0, 1, 0, 1, 32'h0000_0200, 1, 32'h0000_0300, 1, 0, 32'h0040_0104, 1, 1);
    step("br_pend",  0, 1, 0, 0, 0, 1, 32'h0000_0300, 0, 0, 32'h0000_0200, 0, 1);
    step("br_seq",   0, 1, 0, 0, 0, 1, 32'h0000_0300, 1, 0, 32'h0000_0204, 1, 1);
    step("br_tgt",   0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0300, 0, 1);

    // stall during PENDING holds pc and the saved target
    step("st_ack", 0, 1, 0, 1, 32'h0000_0500, 0, 0, 1, 0, 32'h0000_0304, 1, 1);
    step("st_h0",  0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0000_0304, 1, 1);
    step("st_h1",  0, 1, 1, 0, 0, 1, 32'h0000_0700, 0, 0, 32'h0000_0304, 1, 1);
    step("st_h2",  0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0000_0304, 1, 1);
    step("st_rel", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0500, 0, 1);
    step("imem_hold", 0, 0, 0, 1, 32'h0000_0800, 0, 0, 0, 0, 32'h0000_0500, 0, 1);

    // reset in PENDING discards the saved target
    step("rp_ack", 0, 1, 0, 1, 32'h0000_0900, 0, 0, 1, 0, 32'h0000_0504, 1, 1);
    step("rp_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, RPC, 0, 0);
    step("rp_fv",  0, 1, 0, 1, 32'h0000_0A00, 0, 0, 0, 0, RPC, 0, 1);
    step("rp_seq", 0, 1, 0, 0, 0, 0, 0, 0, 0, RPC + 32'd4, 0, 1);

    // wrap modulo 2^32
    step("wr_ack", 0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 0, RPC + 32'd8, 1, 1);
    step("wr_tgt", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 1);
    chk("wr.pc_plus4", pc_plus4, 32'h0000_0000);
    chk("wr.pc_upper", {28'b0, pc_upper}, 32'h0);
    step("wr_wrap", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 1);

    // pc_upper comes from pc+4 at a 256 MB boundary (branch path)
    step("up_ack", 0, 1, 0, 0, 0, 1, 32'h0FFF_FFFC, 1, 0, 32'h0000_0004, 1, 1);
    step("up_tgt", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0FFF_FFFC, 0, 1);
    chk("up.pc_upper", {28'b0, pc_upper}, 32'h1);

    // misaligned target
    if (ALIGN_EN) begin
      step("al_ack", 0, 1, 0, 1, 32'h0040_0102, 0, 0, 1, 1, 32'h1000_0000, 0, 1);
      step("al_seq", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1000_0004, 0, 1);
    end else begin
      step("al_ack", 0, 1, 0, 1, 32'h0040_0102, 0, 0, 1, 0, 32'h1000_0000, 1, 1);
      step("al_tgt", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0100, 0, 1);
    end

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Program counter register and next-PC sequencer for the MIPS fetch stage.
- Consumes the jump targets built by the jump-address formation logic and the branch targets from the branch adder.
- Drives the current PC and PC+4 back to those units; pc_upper supplies the PC+4 upper bits used in jump targets.
- Implements MIPS branch-delay-slot semantics with a two-state redirect FSM and a fetch-ready/stall handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DELAY_SLOT, 1. 1 means a taken redirect executes one delay-slot instruction before the target. 0 means immediate redirect.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- imem_ready  input  1  instruction memory accepted current pc this cycle
- stall  input  1  pipeline hazard hold; freezes pc
- jump_taken  input  1  jump redirect request; held by producer until redirect_ack
- jump_target  input  32  jump destination
- branch_taken  input  1  branch redirect request; held until redirect_ack
- branch_target  input  32  branch destination
- pc  output  32  current fetch address
- pc_plus4  output  32  pc + 4, combinational
- pc_upper  output  4  pc_plus4[31:28], for jump-target formation
- fetch_valid  output  1  pc is a valid fetch address
- delay_slot  output  1  current pc is a delay-slot fetch
- redirect_ack  output  1  redirect request accepted this cycle, combinational
- align_fault  output  1  misaligned target rejected (see Optional Feature)

Behaviour:
- Reset values: pc=RESET_PC; state=SEQ; saved target=0; fetch_valid=0; delay_slot=0; align_fault=0.
- Reset during PENDING discards the saved target.
- fetch_valid goes to 1 on the first clock edge after reset deasserts and stays 1 until the next reset.
- advance = imem_ready & ~stall & fetch_valid. With advance=0, pc, state and saved target all hold, and redirect_ack=0.
- Redirect request: req = jump_taken | branch_taken. When both are asserted, jump has priority; the branch stays unacknowledged and its producer must drop it (squashed).
- redirect_ack = advance & req & (state==SEQ).
- State SEQ:
  - advance & ~req: pc <= pc+4.
  - advance & req & DELAY_SLOT=1: pc <= pc+4; saved <= target; delay_slot <= 1; go to PENDING.
  - advance & req & DELAY_SLOT=0: pc <= target; stay in SEQ.
- State PENDING:
  - advance: pc <= saved; delay_slot <= 0; go to SEQ.
  - Requests in PENDING get no ack. A redirect in a delay slot is ignored; the producer holds it and it is accepted once the FSM returns to SEQ.
- Latency: pc updates one cycle after the accepting edge. A delay-slot redirect reaches the target two advancing cycles after ack.
- Arithmetic: pc+4 wraps modulo 2^32, so 32'hFFFF_FFFC goes to 32'h0000_0000.
- pc_upper is taken from pc_plus4, not pc. This matters at a 256 MB boundary: pc=32'h0FFF_FFFC gives pc_upper=4'h1.
- Targets are used unmodified except for bits [1:0] (see Optional Feature).

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A request whose selected target has [1:0]!=2'b00 is not followed. redirect_ack still pulses so the producer releases.
  - align_fault pulses high for exactly that acceptance cycle (combinational with ack).
  - pc advances sequentially (pc+4) and no PENDING state is entered.
- Not defined:
  - align_fault is tied 0.
  - Target bits [1:0] are forced to 2'b00 before use.

Test Plan:
- Reset with RESET_PC=32'h0040_0000, then 3 cycles with imem_ready=1 and stall=0 -> pc sequence 0040_0000, 0040_0004, 0040_0008; fetch_valid=1 from the first post-reset edge.
- DELAY_SLOT=1, jump_taken=1 with target 32'h0040_0100 at pc=0040_0008 -> ack=1 that cycle; next pc=0040_000C with delay_slot=1; then pc=0040_0100 with delay_slot=0.
- jump_taken and branch_taken asserted together, targets 0x200 and 0x300 -> jump is taken, final pc=0x200. A branch_taken asserted while in PENDING gets no ack until the FSM returns to SEQ.
- stall=1 for 3 cycles during PENDING -> pc and saved target hold; on stall release, pc goes to the saved target. Reset asserted in PENDING -> pc=RESET_PC, delay_slot=0, target discarded.
- pc=32'hFFFF_FFFC, advance -> pc=0000_0000. At pc=32'h0FFF_FFFC -> pc_upper=4'h1.
- With PC_ALIGN_CHECK_EN, jump_target=32'h0040_0102 -> ack=1, align_fault=1 for 1 cycle, pc continues to pc+4. Without the macro -> pc reaches 32'h0040_0100 after the delay slot.
